// File: rtl/counter_pkg.sv
// Shared constants and step logic for the synchronous counter family.
// next_count works on a fixed 32-bit view so any counter up to 32 bits can reuse it.
package counter_pkg;

    localparam int CNT_MAX_W = 32;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // Returns {boundary, next}; operands are zero-extended by the caller.
    function automatic logic [CNT_MAX_W:0] next_count(
        input logic [CNT_MAX_W-1:0] count,
        input logic [CNT_MAX_W-1:0] max_val,
        input logic                 up_dn,
        input logic                 sat
    );
        logic                 boundary;
        logic [CNT_MAX_W-1:0] nxt;
        if (up_dn) begin
            boundary = (count >= max_val);
            if (boundary) nxt = sat ? max_val : '0;
            else          nxt = count + 1'b1;
        end else begin
            boundary = (count == '0);
            if (boundary) nxt = sat ? '0 : max_val;
            else          nxt = count - 1'b1;
        end
        return {boundary, nxt};
    endfunction

endpackage

// File: rtl/sync_mod_counter.sv
// Fully synchronous up/down modulus counter with load, wrap/saturate mode and event flags.
// tc predicts a boundary on the next edge so instances chain through tc -> en.
module sync_mod_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic SAT_MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

    logic [CNT_MAX_W:0] step;
    logic               boundary;
    logic [WIDTH-1:0]   next_val;

    assign step     = next_count(CNT_MAX_W'(count), CNT_MAX_W'(max_val), up_dn, SAT_MODE);
    assign boundary = step[CNT_MAX_W];
    assign next_val = WIDTH'(step);

    assign tc = en & ((up_dn & (count >= max_val)) | (~up_dn & (count == '0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RESET_VAL;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= RESET_VAL;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_val;
            wrap  <= 1'b0;
        end else if (en) begin
            count <= next_val;
            wrap  <= boundary;
            if (boundary) ovf <= 1'b1;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_mod_counter.sv
// Bench for sync_mod_counter: three instances (4-bit wrap, 4-bit saturate, 8-bit wrap)
// driven in lockstep and compared with a modulus-arithmetic reference model.
module tb_sync_mod_counter;

    logic       clk = 1'b0;
    logic       rst, en, clr, load, up_dn;
    logic [3:0] max4, ld4;
    logic [7:0] max8, ld8;
    logic [3:0] c4w, c4s;
    logic [7:0] c8w;
    logic       tc4w, tc4s, tc8w, w4w, w4s, w8w, o4w, o4s, o8w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_mod_counter #(.WIDTH(4), .SATURATE(0), .RESET_VAL(4'd0)) u_w4 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(ld4),
        .up_dn(up_dn), .max_val(max4), .count(c4w), .tc(tc4w), .wrap(w4w), .ovf(o4w));
    sync_mod_counter #(.WIDTH(4), .SATURATE(1), .RESET_VAL(4'd0)) u_s4 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(ld4),
        .up_dn(up_dn), .max_val(max4), .count(c4s), .tc(tc4s), .wrap(w4s), .ovf(o4s));
    sync_mod_counter #(.WIDTH(8), .SATURATE(0), .RESET_VAL(8'd0)) u_w8 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(ld8),
        .up_dn(up_dn), .max_val(max8), .count(c8w), .tc(tc8w), .wrap(w8w), .ovf(o8w));

    logic [7:0] oc[3];
    logic       ot[3], ow[3], oo[3];
    assign oc[0] = {4'd0, c4w};
    assign oc[1] = {4'd0, c4s};
    assign oc[2] = c8w;
    assign ot[0] = tc4w;  assign ot[1] = tc4s;  assign ot[2] = tc8w;
    assign ow[0] = w4w;   assign ow[1] = w4s;   assign ow[2] = w8w;
    assign oo[0] = o4w;   assign oo[1] = o4s;   assign oo[2] = o8w;

    // Reference model: plain integer counting within [0, max] per instance.
    int mc[3], mw[3], mo[3];

    function automatic int mx(int i);
        return (i == 2) ? int'(max8) : int'(max4);
    endfunction
    function automatic int ml(int i);
        return (i == 2) ? int'(ld8) : int'(ld4);
    endfunction
    function automatic bit mtc(int i);
        if (!en) return 1'b0;
        return up_dn ? (mc[i] >= mx(i)) : (mc[i] == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            bit hit;
            if (rst || clr) begin
                mc[i] = 0; mw[i] = 0; mo[i] = 0;
            end else if (load) begin
                mc[i] = ml(i); mw[i] = 0;
            end else if (en) begin
                hit = up_dn ? (mc[i] >= mx(i)) : (mc[i] == 0);
                if (!hit)        mc[i] = up_dn ? mc[i] + 1 : mc[i] - 1;
                else if (i == 1) mc[i] = up_dn ? mx(i) : 0;
                else             mc[i] = up_dn ? 0 : mx(i);
                mw[i] = hit;
                if (hit) mo[i] = 1;
            end else begin
                mw[i] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 0; clr = 0; load = 0; up_dn = 1; max4 = 4'd9; max8 = 8'd255;
        ld4 = 0; ld8 = 0;
        #2;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (oc[i] !== 8'd0 || ow[i] !== 1'b0 || oo[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_init[%0d] count=%0d wrap=%b ovf=%b want 0/0/0", i, oc[i], ow[i], oo[i]);
            end
        end
        @(negedge clk); rst = 1'b0; en = 1'b1;
        repeat (5) tick();
        total++;
        if (c4w !== 4'd5) begin bad++; $display("FAIL reset_precount count=%0d want=5", c4w); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (c4w !== 4'd0 || w4w !== 1'b0 || o4w !== 1'b0 || c8w !== 8'd0) begin
            bad++;
            $display("FAIL reset_async count=%0d wrap=%b ovf=%b c8=%0d want 0/0/0/0", c4w, w4w, o4w, c8w);
        end
        @(negedge clk); rst = 1'b0; en = 1'b0;
        tick();
    endtask

    task automatic test_wrap_up();
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; up_dn = 1'b1; max4 = 4'd9;
        #1;
        for (int k = 0; k < 10; k++) begin
            total++;
            if (c4w !== 4'(k) || tc4w !== (k == 9)) begin
                bad++;
                $display("FAIL wrap_up_seq k=%0d count=%0d tc=%b want %0d/%b", k, c4w, tc4w, k, (k == 9));
            end
            tick();
        end
        total++;
        if (c4w !== 4'd0 || w4w !== 1'b1 || o4w !== 1'b1) begin
            bad++; $display("FAIL wrap_up_edge count=%0d wrap=%b ovf=%b want 0/1/1", c4w, w4w, o4w);
        end
        tick();
        total++;
        if (c4w !== 4'd1 || w4w !== 1'b0 || o4w !== 1'b1) begin
            bad++; $display("FAIL wrap_up_after count=%0d wrap=%b ovf=%b want 1/0/1", c4w, w4w, o4w);
        end
    endtask

    task automatic test_wrap_down();
        int ec[3] = '{1, 0, 9};
        bit ew[3] = '{0, 0, 1};
        bit et[3] = '{0, 1, 0};
        load = 1'b1; ld4 = 4'd2; tick(); load = 1'b0;
        up_dn = 1'b0; en = 1'b1; max4 = 4'd9;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (c4w !== 4'(ec[k]) || w4w !== ew[k] || tc4w !== et[k]) begin
                bad++;
                $display("FAIL wrap_down k=%0d count=%0d wrap=%b tc=%b want %0d/%b/%b",
                         k, c4w, w4w, tc4w, ec[k], ew[k], et[k]);
            end
        end
    endtask

    task automatic test_saturate();
        int ec[4] = '{11, 12, 12, 12};
        bit ew[4] = '{0, 0, 1, 1};
        en = 1'b0; max4 = 4'd12; load = 1'b1; ld4 = 4'd10; tick(); load = 1'b0;
        en = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (c4s !== 4'(ec[k]) || w4s !== ew[k]) begin
                bad++;
                $display("FAIL sat_up k=%0d count=%0d wrap=%b want %0d/%b", k, c4s, w4s, ec[k], ew[k]);
            end
        end
        load = 1'b1; ld4 = 4'd1; tick(); load = 1'b0; up_dn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (c4s !== 4'd0 || w4s !== (k == 1) || o4s !== 1'b1) begin
                bad++;
                $display("FAIL sat_down k=%0d count=%0d wrap=%b ovf=%b want 0/%b/1", k, c4s, w4s, o4s, (k == 1));
            end
        end
    endtask

    task automatic test_priority();
        clr = 1'b1; tick(); clr = 1'b0;
        max4 = 4'd9; ld4 = 4'd14; load = 1'b1; en = 1'b1; up_dn = 1'b1;
        tick(); load = 1'b0;
        total++;
        if (c4w !== 4'd14 || w4w !== 1'b0 || o4w !== 1'b0) begin
            bad++; $display("FAIL load_over count=%0d wrap=%b ovf=%b want 14/0/0", c4w, w4w, o4w);
        end
        tick();
        total++;
        if (c4w !== 4'd0 || w4w !== 1'b1 || o4w !== 1'b1) begin
            bad++; $display("FAIL load_over_step count=%0d wrap=%b ovf=%b want 0/1/1", c4w, w4w, o4w);
        end
        tick();
        clr = 1'b1; load = 1'b1; ld4 = 4'd5;
        tick(); clr = 1'b0; load = 1'b0;
        total++;
        if (c4w !== 4'd0 || w4w !== 1'b0 || o4w !== 1'b0) begin
            bad++; $display("FAIL clr_over_load count=%0d wrap=%b ovf=%b want 0/0/0", c4w, w4w, o4w);
        end
    endtask

    task automatic test_edge_moduli();
        max4 = 4'd0; clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) up_dn = 1'b0;
            #1;
            total++;
            if (tc4w !== 1'b1) begin bad++; $display("FAIL mod1_tc k=%0d tc=%b want 1", k, tc4w); end
            tick();
            total++;
            if (c4w !== 4'd0 || w4w !== 1'b1) begin
                bad++; $display("FAIL mod1 k=%0d count=%0d wrap=%b want 0/1", k, c4w, w4w);
            end
        end
        up_dn = 1'b1; max8 = 8'd255; ld8 = 8'd254; load = 1'b1; tick(); load = 1'b0;
        tick();
        total++;
        if (c8w !== 8'd255 || w8w !== 1'b0 || tc8w !== 1'b1) begin
            bad++; $display("FAIL full_top count=%0d wrap=%b tc=%b want 255/0/1", c8w, w8w, tc8w);
        end
        tick();
        total++;
        if (c8w !== 8'd0 || w8w !== 1'b1) begin
            bad++; $display("FAIL full_wrap count=%0d wrap=%b want 0/1", c8w, w8w);
        end
        en = 1'b0; tick();
        total++;
        if (c8w !== 8'd0 || w8w !== 1'b0 || tc8w !== 1'b0) begin
            bad++; $display("FAIL hold count=%0d wrap=%b tc=%b want 0/0/0", c8w, w8w, tc8w);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            en    = ($urandom_range(0, 3) != 0);
            up_dn = $urandom_range(0, 1);
            clr   = ($urandom_range(0, 39) == 0);
            load  = ($urandom_range(0, 14) == 0);
            ld4   = 4'($urandom);
            ld8   = 8'($urandom);
            if ($urandom_range(0, 19) == 0) max4 = 4'($urandom);
            if ($urandom_range(0, 19) == 0) max8 = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
            if ($urandom_range(0, 96) == 0) begin
                rst = 1'b1; #1 rst = 1'b0;
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (ot[i] !== mtc(i)) begin
                    bad++; $display("FAIL rand_tc n=%0d inst=%0d tc=%b want=%b", n, i, ot[i], mtc(i));
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                total++;
                if (oc[i] !== 8'(mc[i]) || ow[i] !== mw[i][0] || oo[i] !== mo[i][0]) begin
                    bad++;
                    $display("FAIL rand_state n=%0d inst=%0d count=%0d wrap=%b ovf=%b want %0d/%0d/%0d",
                             n, i, oc[i], ow[i], oo[i], mc[i], mw[i], mo[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_priority();
        test_edge_moduli();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_mod_counter.md
Name: sync_mod_counter

Overview:
- Fully synchronous, parametrised up/down counter with programmable modulus, parallel load, wrap or saturate mode, and event flags.
- Next generation of the ripple-counter family: every bit is clocked by the single system clock, so there is no ripple skew and the count is valid on every edge.
- Used as the timebase and event counter in datapath and timer blocks.
- Flags are intended for cascading and interrupt generation.

Parameters:
- WIDTH, 8: counter width in bits, minimum 2.
- SATURATE, 0: 0 = wrap at the modulus boundary; 1 = hold at the boundary.
- RESET_VAL, 0: count value after reset or clr, WIDTH bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; one step per clk edge while high.
- clr  in  1  synchronous clear to RESET_VAL; also clears ovf.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value for load; loaded unchecked.
- up_dn  in  1  1 = count up, 0 = count down.
- max_val  in  WIDTH  terminal value; modulus = max_val+1; may change at any time.
- count  out  WIDTH  registered count.
- tc  out  1  combinational terminal-count indicator.
- wrap  out  1  registered one-cycle pulse after a wrap or saturate-boundary hit.
- ovf  out  1  sticky registered overflow/underflow flag.

Behaviour:
- Reset (rst high, asynchronous):
  - count = RESET_VAL, wrap = 0, ovf = 0 immediately.
  - Held while rst is high.
  - Deassertion is synchronised externally.
- Per-edge priority: rst > clr > load > en. Lower-priority actions in the same cycle are ignored.
- clr: count <= RESET_VAL, wrap <= 0, ovf <= 0.
- load: count <= load_val, wrap <= 0, ovf unchanged. A loaded value above max_val is legal.
- Enabled step, up (up_dn = 1):
  - If count >= max_val, this is a boundary event:
    - SATURATE = 0: count <= 0.
    - SATURATE = 1: count <= max_val.
  - Otherwise count <= count+1.
- Enabled step, down (up_dn = 0):
  - If count == 0, this is a boundary event:
    - SATURATE = 0: count <= max_val.
    - SATURATE = 1: count <= 0.
  - Otherwise count <= count-1. A count above max_val decrements normally.
- Boundary event side effects:
  - wrap <= 1 for exactly one cycle, coincident with the new count.
  - ovf <= 1 and stays set until clr or rst.
  - In saturate mode, wrap pulses on every enabled cycle spent at the boundary.
- wrap <= 0 on every cycle without a boundary event, including en low.
- tc = en & ((up_dn & count >= max_val) | (~up_dn & count == 0)). It predicts a boundary event at the next edge, for cascading into a following stage's en.
- max_val = 0: the counter is a modulus-1 counter, with count stuck at 0 and wrap pulsing every enabled cycle.
- max_val = all-ones: full 2^WIDTH range; arithmetic is WIDTH-bit with no extra carry bit needed.
- Direction change takes effect on the same edge; there is no pipeline latency.
- Reset mid-count aborts immediately; there is no pending state.

Decomposition:
- Package counter_pkg holds:
  - MODE_WRAP = 0 and MODE_SAT = 1 constants for SATURATE;
  - a function next_count(count, max_val, up_dn, sat) returning {boundary, next}, shared with later timer blocks.
- No sub-module: a single always block for state plus one continuous assign for tc.
- Cascaded wide counters are built by chaining instances via tc -> en.

Test Plan:
- Reset: rst high mid-count (count = 5) -> count = RESET_VAL = 0, wrap = 0, ovf = 0 without waiting for a clk edge.
- Wrap up: WIDTH = 4, max_val = 9, en = 1, up_dn = 1 from 0 -> counts 0..9; tc = 1 at 9; next edge count = 0, wrap = 1 for one cycle; ovf = 1 and stays set.
- Wrap down: max_val = 9, up_dn = 0 from 2 -> 2,1,0,9; tc high at 0; wrap pulse with count = 9.
- Saturate: SATURATE = 1, max_val = 12, count up from 10 -> 11, 12, 12, 12; wrap high on each enabled cycle at 12; down from 1 -> 0, 0.
- Priority/load: load_val = 14 with max_val = 9, load = 1, en = 1 -> count = 14, wrap = 0. Next up step -> count = 0, wrap = 1. clr + load same cycle -> RESET_VAL, ovf = 0.
- Edge moduli: max_val = 0 -> count stays 0, wrap every enabled cycle. max_val = 255 at WIDTH = 8 -> 255 -> 0 with wrap; en = 0 -> count holds, wrap = 0, tc = 0.
